// File: rtl/dmem_access_sequencer.sv
// Two-port round-robin arbiter and big-endian byte sequencer for the byte-wide data memory.
// Each granted request becomes one error response or 1/2/4 single-byte memory cycles followed by a response.
module dmem_access_sequencer #(
  parameter int ADDR_W    = 12,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_sign,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_size,
  input  logic              b_sign,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1, ST_RESP = 2'd2} state_t;

  localparam logic [32:0] LAST_ADDR = 33'(MEM_DEPTH - 1);

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b11:   return 3'd4;
      2'b10:   return 3'd2;
      2'b01:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] data, input logic [1:0] idx);
    return data[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] val, input logic [2:0] n, input logic sign);
    case (n)
      3'd1:    return {{24{sign & val[7]}}, val[7:0]};
      3'd2:    return {{16{sign & val[15]}}, val[15:0]};
      default: return val;
    endcase
  endfunction

  state_t        state_r, state_nxt_s;
  logic          last_grant_r;
  logic          we_r, sign_r, id_r;
  logic [2:0]    n_r;
  logic [1:0]    cnt_r;
  logic [31:0]   wdata_r, acc_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic          mem_we_r;
  logic [7:0]    mem_wdata_r;
  logic          resp_valid_r, resp_id_r, resp_err_r;
  logic [31:0]   resp_rdata_r;

  logic          pick_b_s, grant_s;
  logic          sel_we_s, sel_sign_s;
  logic [1:0]    sel_size_s;
  logic [31:0]   sel_addr_s, sel_wdata_s;
  logic [2:0]    sel_n_s, nxt_idx_s;
  logic [32:0]   end_addr_s;
  logic          sel_err_s, last_s;
  logic [31:0]   shift_s;

  // Last grant (1 = B) only breaks ties, so A wins the first tie after reset.
  assign pick_b_s = b_req & (~a_req | ~last_grant_r);
  assign grant_s  = (state_r == ST_IDLE) & (a_req | b_req) & ~reset;
  assign a_gnt    = grant_s & ~pick_b_s;
  assign b_gnt    = grant_s & pick_b_s;

  // Select the winning requester's fields.
  always_comb begin
    sel_we_s    = a_we;
    sel_sign_s  = a_sign;
    sel_size_s  = a_size;
    sel_addr_s  = a_addr;
    sel_wdata_s = a_wdata;
    if (pick_b_s) begin
      sel_we_s    = b_we;
      sel_sign_s  = b_sign;
      sel_size_s  = b_size;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_we_s    = a_we;
    end
  end

  assign sel_n_s    = size_bytes(sel_size_s);
  assign end_addr_s = {1'b0, sel_addr_s} + {30'd0, sel_n_s} - 33'd1;
  assign sel_err_s  = (sel_n_s == 3'd0)
                    | ((sel_size_s == 2'b11) & (sel_addr_s[1:0] != 2'b00))
                    | ((sel_size_s == 2'b10) & sel_addr_s[0])
                    | (end_addr_s > LAST_ADDR);
  assign last_s     = ({1'b0, cnt_r} == (n_r - 3'd1));
  assign nxt_idx_s  = n_r - 3'd2 - {1'b0, cnt_r};
  assign shift_s    = {acc_r[23:0], mem_rdata};

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = sel_err_s ? ST_RESP : ST_XFER;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (last_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, capture, memory-cycle and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      we_r         <= 1'b0;
      sign_r       <= 1'b0;
      id_r         <= 1'b0;
      n_r          <= 3'd0;
      cnt_r        <= 2'd0;
      wdata_r      <= 32'd0;
      acc_r        <= 32'd0;
      mem_addr_r   <= '0;
      mem_we_r     <= 1'b0;
      mem_wdata_r  <= 8'd0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            if (a_req & b_req) begin
              last_grant_r <= pick_b_s;
            end
            we_r    <= sel_we_s;
            sign_r  <= sel_sign_s;
            id_r    <= pick_b_s;
            n_r     <= sel_n_s;
            wdata_r <= sel_wdata_s;
            cnt_r   <= 2'd0;
            acc_r   <= 32'd0;
            if (sel_err_s) begin
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_id_r    <= pick_b_s;
              resp_rdata_r <= 32'd0;
            end else begin
              mem_addr_r  <= sel_addr_s[ADDR_W-1:0];
              mem_we_r    <= sel_we_s;
              mem_wdata_r <= pick_byte(sel_wdata_s, 2'(sel_n_s - 3'd1));
            end
          end
        end
        ST_XFER: begin
          cnt_r <= cnt_r + 2'd1;
          if (!we_r) begin
            acc_r <= shift_s;
          end
          if (last_s) begin
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_id_r    <= id_r;
            resp_rdata_r <= we_r ? 32'd0 : extend(shift_s, n_r, sign_r);
          end else begin
            mem_addr_r  <= mem_addr_r + 1'b1;
            mem_wdata_r <= pick_byte(wdata_r, nxt_idx_s[1:0]);
          end
        end
        default: begin
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr   = mem_addr_r;
  assign mem_we     = mem_we_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Directed plus randomized bench for dmem_access_sequencer with a byte-array reference model.
module tb_dmem_access_sequencer;
  localparam int ADDR_W    = 12;
  localparam int MEM_DEPTH = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, a_sign = 1'b0;
  logic [1:0] a_size = 2'b00;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic b_req = 1'b0, b_we = 1'b0, b_sign = 1'b0;
  logic [1:0] b_size = 2'b00;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic a_gnt, b_gnt, mem_we, resp_valid, resp_id, resp_err, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:MEM_DEPTH-1];
  logic mem_clr = 1'b1;
  logic [7:0] ref_mem [0:MEM_DEPTH-1];

  dmem_access_sequencer #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_sign(a_sign),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_sign(b_sign),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte-wide memory array: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'd0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    if (size == 2'd3) return 4;
    if (size == 2'd2) return 2;
    if (size == 2'd1) return 1;
    return 0;
  endfunction

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    longint n = longint'(nbytes(size));
    longint a = longint'({32'd0, addr});
    if (n == 0) return 1'b1;
    if (a % n != 0) return 1'b1;
    return (a + n > MEM_DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign, input logic [31:0] addr);
    longint v = 0;
    longint one = 1;
    int n = nbytes(size);
    for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[addr + i]);
    if (sign && n < 4 && v >= (one << (8 * n - 1))) v = v - (one << (8 * n));
    return v[31:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " a_gnt"}, 32'(a_gnt), 32'd0);
    check({tag, " b_gnt"}, 32'(b_gnt), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " resp_id"}, 32'(resp_id), 32'd0);
    check({tag, " resp_rdata"}, resp_rdata, 32'd0);
    check({tag, " resp_err"}, 32'(resp_err), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // One complete transaction on one port, checked against the reference model.
  task automatic txn(input bit port, input bit we, input logic [1:0] size, input bit sign,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                     output logic [31:0] rd);
    int n, lat, waited;
    bit err, done, gnt;
    logic [31:0] exp;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [7:0] wq_data[$];
    n   = nbytes(size);
    err = ref_err(size, addr);
    exp = (we || err) ? 32'd0 : ref_load(size, sign, addr);
    rd  = 32'hDEADBEEF;
    @(negedge clk);
    if (port) begin
      b_we = we; b_size = size; b_sign = sign; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end else begin
      a_we = we; a_size = size; a_sign = sign; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end
    waited = 0;
    #1;
    gnt = port ? b_gnt : a_gnt;
    while (!gnt && waited < 20) begin
      @(negedge clk); #1; waited++;
      gnt = port ? b_gnt : a_gnt;
    end
    check({tag, " gnt"}, 32'(gnt), 32'd1);
    if (gnt) begin
      check({tag, " other gnt"}, 32'(port ? a_gnt : b_gnt), 32'd0);
      @(negedge clk);
      a_req = 1'b0; b_req = 1'b0;
      lat = 1; done = 1'b0;
      while (!done && lat <= 8) begin
        #1;
        if (mem_we) begin
          wq_addr.push_back(mem_addr);
          wq_data.push_back(mem_wdata);
        end
        if (resp_valid) done = 1'b1;
        else begin
          @(negedge clk); lat++;
        end
      end
      check({tag, " latency"}, 32'(lat), err ? 32'd1 : 32'(n + 1));
      check({tag, " resp_id"}, 32'(resp_id), 32'(port));
      check({tag, " resp_err"}, 32'(resp_err), 32'(err));
      check({tag, " resp_rdata"}, resp_rdata, exp);
      check({tag, " busy in resp"}, 32'(busy), 32'd1);
      rd = resp_rdata;
      check({tag, " write count"}, 32'(wq_addr.size()), (we && !err) ? 32'(n) : 32'd0);
      for (int k = 0; k < wq_addr.size() && k < n; k++) begin
        check({tag, " write addr"}, 32'(wq_addr[k]), (addr + 32'(k)) & 32'hFFF);
        check({tag, " write data"}, 32'(wq_data[k]), (wdata >> (8 * (n - 1 - k))) & 32'hFF);
      end
      if (we && !err) begin
        for (int k = 0; k < n; k++) ref_mem[addr + k] = 8'((wdata >> (8 * (n - 1 - k))) & 32'hFF);
      end
    end else begin
      a_req = 1'b0; b_req = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit order [4];
    bit exp_last;
    int ngrant, nresp, cyc, r;
    logic [31:0] raddr;

    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;

    txn(1'b0, 1'b1, 2'b11, 1'b0, 32'd4, 32'h01234567, "st_w4", rd);
    txn(1'b0, 1'b0, 2'b11, 1'b0, 32'd4, 32'd0, "ld_w4", rd);
    check("ld_w4 const", rd, 32'h01234567);
    txn(1'b1, 1'b1, 2'b01, 1'b0, 32'd10, 32'h00000080, "st_b10", rd);
    txn(1'b1, 1'b1, 2'b01, 1'b0, 32'd11, 32'h00000001, "st_b11", rd);
    txn(1'b1, 1'b1, 2'b01, 1'b0, 32'd13, 32'h0000009C, "st_b13", rd);
    txn(1'b0, 1'b0, 2'b10, 1'b1, 32'd10, 32'd0, "ld_h10s", rd);
    check("ld_h10s const", rd, 32'hFFFF8001);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'd10, 32'd0, "ld_h10z", rd);
    check("ld_h10z const", rd, 32'h00008001);
    txn(1'b0, 1'b0, 2'b01, 1'b1, 32'd13, 32'd0, "ld_b13s", rd);
    check("ld_b13s const", rd, 32'hFFFFFF9C);
    txn(1'b1, 1'b0, 2'b01, 1'b0, 32'd13, 32'd0, "ld_b13z", rd);
    check("ld_b13z const", rd, 32'h0000009C);
    txn(1'b0, 1'b1, 2'b01, 1'b0, 32'd13, 32'h00000067, "st_b13", rd);
    txn(1'b0, 1'b0, 2'b11, 1'b0, 32'd12, 32'd0, "ld_w12", rd);
    check("ld_w12 const", rd, 32'h00670000);

    txn(1'b1, 1'b0, 2'b11, 1'b0, 32'd6, 32'd0, "err_w6", rd);
    txn(1'b0, 1'b0, 2'b10, 1'b0, 32'd3, 32'd0, "err_h3", rd);
    txn(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 32'h12345678, "err_sz0", rd);
    txn(1'b1, 1'b1, 2'b11, 1'b0, 32'd4094, 32'hCAFEF00D, "err_w4094", rd);
    check("err_w4094 rdata", rd, 32'd0);

    // Contending byte loads after a reset: round-robin starting with A.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    exp_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      order[i] = ~exp_last;
      exp_last = order[i];
    end
    a_we = 1'b0; a_size = 2'b01; a_sign = 1'b0; a_addr = 32'd13; a_req = 1'b1;
    b_we = 1'b0; b_size = 2'b01; b_sign = 1'b0; b_addr = 32'd10; b_req = 1'b1;
    ngrant = 0; nresp = 0; cyc = 0;
    while (nresp < 4 && cyc < 40) begin
      #1;
      if (busy) check("arb no gnt while busy", {30'd0, a_gnt, b_gnt}, 32'd0);
      if ((a_gnt || b_gnt) && ngrant < 4) begin
        check("arb gnt is b", 32'(b_gnt), 32'(order[ngrant]));
        ngrant++;
      end
      if (resp_valid && nresp < 4) begin
        check("arb resp_id", 32'(resp_id), 32'(order[nresp]));
        check("arb resp_rdata", resp_rdata, ref_load(2'b01, 1'b0, order[nresp] ? 32'd10 : 32'd13));
        nresp++;
      end
      @(negedge clk);
      cyc++;
      if (ngrant == 4) begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("arb grant count", 32'(ngrant), 32'd4);
    check("arb resp count", 32'(nresp), 32'd4);

    // Reset during the second byte of a word store to address 8.
    @(negedge clk);
    a_we = 1'b1; a_size = 2'b11; a_sign = 1'b0; a_addr = 32'd8; a_wdata = 32'hAABBCCDD; a_req = 1'b1;
    #1;
    check("rst_mid gnt", 32'(a_gnt), 32'd1);
    @(negedge clk);
    a_req = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid addr cycle1", 32'(mem_addr), 32'd9);
    check("rst_mid we cycle1", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    r = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (resp_valid || mem_we) r++;
    end
    check("rst_mid no resp or write", 32'(r), 32'd0);
    ref_mem[8] = 8'hAA;
    ref_mem[9] = 8'hBB;
    check("rst_mid mem8", 32'(mem[8]), 32'hAA);
    check("rst_mid mem9", 32'(mem[9]), 32'hBB);
    check("rst_mid mem10", 32'(mem[10]), 32'h80);
    check("rst_mid mem11", 32'(mem[11]), 32'h01);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) raddr = 32'($urandom_range(0, 63));
      else if (r < 9) raddr = 32'($urandom_range(MEM_DEPTH - 8, MEM_DEPTH - 1));
      else raddr = $urandom;
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), raddr, $urandom, "rand", rd);
    end

    for (int i = 0; i < 64; i++) check("final mem low", 32'(mem[i]), 32'(ref_mem[i]));
    for (int i = MEM_DEPTH - 8; i < MEM_DEPTH; i++) check("final mem top", 32'(mem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_sequencer.md
Name: dmem_access_sequencer

Overview:
Two-port arbiter and byte sequencer in front of the byte-wide data memory array. Accepts word/halfword/byte load and store requests from requester A (load/store unit) and requester B (debug/DMA loader). Grants one request at a time with round-robin arbitration and walks the memory one byte per cycle in big-endian order. Returns a sign- or zero-extended 32-bit result, or an error for illegal accesses.

Parameters:
ADDR_W, 12, width of the byte address driven to the memory array
MEM_DEPTH, 4096, number of addressable bytes; valid byte addresses are 0..MEM_DEPTH-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
a_req  input  1  requester A request; held high until a_gnt
a_we  input  1  A: 1=store, 0=load
a_size  input  2  A access size: 2'b11 word, 2'b10 halfword, 2'b01 byte, 2'b00 illegal
a_sign  input  1  A load extension: 1=sign-extend, 0=zero-extend
a_addr  input  32  A byte address
a_wdata  input  32  A store data, right-justified
a_gnt  output  1  one-cycle pulse: A request accepted and captured this cycle
b_req, b_we, b_size, b_sign, b_addr, b_wdata, b_gnt  same as A, for requester B
mem_addr  output  ADDR_W  byte address to memory array
mem_we  output  1  byte write enable
mem_wdata  output  8  byte write data
mem_rdata  input  8  combinational read byte at mem_addr
resp_valid  output  1  one-cycle pulse: transaction complete
resp_id  output  1  requester of completed transaction: 0=A, 1=B
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  with resp_valid: access rejected, memory untouched
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, XFER, RESP.
- Reset values: state=IDLE, a_gnt=b_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_id=0, resp_rdata=0, resp_err=0, busy=0, last_grant=B, so A wins the first tie.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester that is not last_grant, then update last_grant. Gnt is combinational in that cycle. The request fields (we, size, sign, addr, wdata, id) are captured at that edge. N = 4/2/1 bytes for word/half/byte. No req: stay in IDLE.
- Error check at capture: the access is an error if size=2'b00, a word has addr[1:0]!=0, a halfword has addr[0]!=0, or addr+N-1 > MEM_DEPTH-1 (32-bit compare, no wrap). On error, go IDLE->RESP with resp_err=1 and no memory cycles.
- XFER: cycle k (k=0..N-1) drives mem_addr=addr+k (low ADDR_W bits).
  - Store: mem_we=1 and mem_wdata = wdata byte (N-1-k), i.e. MSB first at the lowest address.
  - Load: mem_we=0 and mem_rdata is shifted into the accumulator at the end of the cycle, so the first byte lands as the most significant.
  - After cycle N-1, go to RESP.
- RESP: one cycle. resp_valid=1 and resp_id = captured id.
  - Load: resp_rdata is the N-byte value, sign-extended from its top bit if sign=1, otherwise zero-extended. Words are unaffected by sign.
  - Store or error: resp_rdata=0.
  - Next state is IDLE. No new grant is issued during the RESP cycle.
- Latency: gnt cycle to resp_valid is N+1 cycles (word 5, half 3, byte 2); error 1 cycle. Throughput is one transaction per N+2 cycles.
- No gnt is issued while busy=1. A req arriving mid-transaction waits.
- mem_we is 0 outside XFER. mem_addr and mem_wdata hold their last values outside XFER.
- Reset asserted mid-XFER: the next edge returns to reset values, and no resp_valid is issued. Bytes already written stay written and the rest are not written. A held req is re-arbitrated after reset deasserts.

Test Plan:
- Memory zeroed. A stores word 0x01234567 at addr 4 -> a_gnt pulse; 4 XFER cycles with mem_we=1, addr 4..7, data 01,23,45,67; resp_valid 5 cycles after gnt with id=0, err=0. A then loads the word -> resp_rdata=0x01234567.
- Bytes 0x80,0x01 at addr 10/11. Halfword load at 10 with sign=1 -> 0xFFFF8001; with sign=0 -> 0x00008001; latency 3 cycles.
- Byte 0x9C at addr 13. Byte load with sign=1 -> 0xFFFFFF9C; with sign=0 -> 0x0000009C; byte store of 0x67 at 13 writes only addr 13.
- a_req and b_req held high continuously for byte loads -> grants in order A,B,A,B; resp_id alternates 0,1,0,1; no gnt while busy=1.
- Word at addr 6, halfword at addr 3, size 2'b00, word at addr 4094 -> each gives resp_err=1 one cycle after gnt, mem_we never asserted, resp_rdata=0.
- Reset pulsed during the 2nd XFER cycle of a word store to addr 8 -> next cycle all outputs at reset values, no resp_valid; bytes at 8 and 9 written, bytes at 10 and 11 unchanged.
